ex_stage: RTL

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage_if.sv | 41 ++++
 rtl/ex_stage.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/ex_stage_if.sv
// Execute-stage bus: ID/EX operands and controls in, registered EX/MEM fields out.
// The master side is the pipeline driver, the slave side is ex_stage.
interface ex_stage_if;
  logic [31:0] ex_final_a;
  logic [31:0] ex_final_b;
  logic [2:0]  ex_alu_op;
  logic        ex_sub;
  logic        ex_slt_and_spin_off_signed;
  logic        ex_slt_and_spin_off_unsigned;
  logic        ex_valid;
  logic        ex_md;
  logic [1:0]  ex_md_op;
  logic        ex_flush;
  logic        ex_is_write_dmem;
  logic [1:0]  ex_wb_select;
  logic [7:0]  ex_write_width;
  logic [31:0] ex_dmem_write_data;
  logic        ex_stall;
  logic        mem_valid;
  logic [31:0] mem_alu_result;
  logic        mem_is_write_dmem;
  logic [1:0]  mem_wb_select;
  logic [7:0]  mem_write_width;
  logic [31:0] mem_dmem_write_data;

  modport master (
    output ex_final_a, ex_final_b, ex_alu_op, ex_sub, ex_slt_and_spin_off_signed,
           ex_slt_and_spin_off_unsigned, ex_valid, ex_md, ex_md_op, ex_flush,
           ex_is_write_dmem, ex_wb_select, ex_write_width, ex_dmem_write_data,
    input  ex_stall, mem_valid, mem_alu_result, mem_is_write_dmem, mem_wb_select,
           mem_write_width, mem_dmem_write_data
  );

  modport slave (
    input  ex_final_a, ex_final_b, ex_alu_op, ex_sub, ex_slt_and_spin_off_signed,
           ex_slt_and_spin_off_unsigned, ex_valid, ex_md, ex_md_op, ex_flush,
           ex_is_write_dmem, ex_wb_select, ex_write_width, ex_dmem_write_data,
    output ex_stall, mem_valid, mem_alu_result, mem_is_write_dmem, mem_wb_select,
           mem_write_width, mem_dmem_write_data
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus, when EX_MDU_EN is defined, an iterative
// 32-step multiply/divide unit that stalls ID/EX while it works.
module ex_stage (
  input  logic      sys_clk,
  input  logic      sys_rst,
  ex_stage_if.slave bus
);
  logic [31:0] alu_result;
  logic        slt_bit;
  logic        stall;
  logic        commit;
  logic [31:0] commit_result;

  always_comb begin
    if (bus.ex_slt_and_spin_off_signed && !bus.ex_slt_and_spin_off_unsigned)
      slt_bit = $signed(bus.ex_final_a) < $signed(bus.ex_final_b);
    else
      slt_bit = bus.ex_final_a < bus.ex_final_b;
  end

  always_comb begin
    alu_result = 32'd0;
    case (bus.ex_alu_op)
      3'b000: alu_result = bus.ex_sub ? bus.ex_final_a - bus.ex_final_b
                                      : bus.ex_final_a + bus.ex_final_b;
      3'b001: alu_result = bus.ex_final_a << bus.ex_final_b[4:0];
      3'b010: alu_result = {31'd0, slt_bit};
      3'b011: alu_result = bus.ex_final_a ^ bus.ex_final_b;
      3'b100: alu_result = bus.ex_sub ? $unsigned($signed(bus.ex_final_a) >>> bus.ex_final_b[4:0])
                                      : bus.ex_final_a >> bus.ex_final_b[4:0];
      3'b101: alu_result = bus.ex_final_a | bus.ex_final_b;
      3'b110: alu_result = bus.ex_final_a & bus.ex_final_b;
      default: alu_result = bus.ex_final_b;
    endcase
  end

`ifdef EX_MDU_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mdu_state_t;

  mdu_state_t  state, state_next;
  logic [4:0]  count;
  logic [1:0]  op_q;
  logic [31:0] opnd_q, hi_q, lo_q, hi_step, lo_step;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic        md_accept, div_by_zero, div_fits;

  assign div_by_zero = bus.ex_md_op[1] && (bus.ex_final_b == 32'd0);

  always_comb begin
    state_next = state;
    md_accept  = 1'b0;
    stall      = 1'b0;
    case (state)
      IDLE: if (bus.ex_valid && bus.ex_md) begin
        md_accept  = 1'b1;
        stall      = 1'b1;
        state_next = div_by_zero ? DONE : BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        if (count == 5'd31) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.ex_flush) state_next = IDLE;
  end

  // hi:lo is the product (multiply) or remainder:quotient-in-progress (divide)
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : 33'd0);
    div_shift = {hi_q, lo_q[31]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_fits  = div_shift >= {1'b0, opnd_q};
    hi_step   = hi_q;
    lo_step   = lo_q;
    if (op_q[1]) begin
      hi_step = div_fits ? div_diff[31:0] : div_shift[31:0];
      lo_step = {lo_q[30:0], div_fits};
    end else begin
      hi_step = mul_sum[32:1];
      lo_step = {mul_sum[0], lo_q[31:1]};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state  <= IDLE;
      count  <= 5'd0;
      op_q   <= 2'd0;
      opnd_q <= 32'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
    end else begin
      state <= state_next;
      if (md_accept) begin
        op_q   <= bus.ex_md_op;
        opnd_q <= bus.ex_final_b;
        count  <= 5'd0;
        hi_q   <= div_by_zero ? bus.ex_final_a : 32'd0;
        lo_q   <= div_by_zero ? 32'hFFFF_FFFF : bus.ex_final_a;
      end else if (state == BUSY) begin
        count <= count + 5'd1;
        hi_q  <= hi_step;
        lo_q  <= lo_step;
      end
    end
  end

  assign commit = !bus.ex_flush &&
                  ((state == DONE) || (state == IDLE && bus.ex_valid && !bus.ex_md));
  assign commit_result = (state == DONE) ? (op_q[0] ? hi_q : lo_q) : alu_result;
`else
  logic unused_md;

  assign unused_md     = ^{bus.ex_md, bus.ex_md_op};
  assign stall         = 1'b0;
  assign commit        = bus.ex_valid && !bus.ex_flush;
  assign commit_result = alu_result;
`endif

  assign bus.ex_stall = stall;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      bus.mem_valid           <= 1'b0;
      bus.mem_alu_result      <= 32'd0;
      bus.mem_is_write_dmem   <= 1'b0;
      bus.mem_wb_select       <= 2'd0;
      bus.mem_write_width     <= 8'd0;
      bus.mem_dmem_write_data <= 32'd0;
    end else if (commit) begin
      bus.mem_valid           <= 1'b1;
      bus.mem_alu_result      <= commit_result;
      bus.mem_is_write_dmem   <= bus.ex_is_write_dmem;
      bus.mem_wb_select       <= bus.ex_wb_select;
      bus.mem_write_width     <= bus.ex_write_width;
      bus.mem_dmem_write_data <= bus.ex_dmem_write_data;
    end else begin
      bus.mem_valid <= 1'b0;
    end
  end
endmodule
